// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//   Shares one asynchronous SRAM between two requesters: port A (video reader)
//   and port B (CPU bridge). Every access takes exactly three cycles:
//   IDLE (request sampled, grant and request registered), ACCESS (SRAM
//   strobes, write pulse) and DONE (ack pulse, write data hold). There is no
//   pipelining; a request held high after its ack is taken as a new request
//   in the following IDLE.
//
//   Parameters
//     ADDR_W   SRAM word-address width
//     DATA_W   SRAM data width (byte enables are DATA_W/8 bits)
//
//   Ports
//     clk, reset                   clock, asynchronous active-high reset
//     a_req/a_we/a_addr/a_wdata/a_be   port A request, direction, address,
//                                      write data, byte enables (bit1 = upper)
//     a_ack/a_rdata                port A one-cycle completion, read data
//     b_*                          same set for port B
//     SRAM_ADDR, SRAM_DQ           SRAM address and bidirectional data bus
//     SRAM_CE_N/OE_N/WE_N/UB_N/LB_N    SRAM controls, active-low
//
//   Configuration macro
//     SRAM_ARB_ROUND_ROBIN_EN  defined: simultaneous requests alternate,
//                              starting with A after reset.
//                              undefined: A always wins simultaneous requests.
// ---------------------------------------------------------------------------
module sram_arbiter #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  input  logic [DATA_W/8-1:0]   a_be,
  output logic                  a_ack,
  output logic [DATA_W-1:0]     a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_wdata,
  input  logic [DATA_W/8-1:0]   b_be,
  output logic                  b_ack,
  output logic [DATA_W-1:0]     b_rdata,
  output logic [ADDR_W-1:0]     SRAM_ADDR,
  inout  wire  [DATA_W-1:0]     SRAM_DQ,
  output logic                  SRAM_CE_N,
  output logic                  SRAM_OE_N,
  output logic                  SRAM_WE_N,
  output logic                  SRAM_UB_N,
  output logic                  SRAM_LB_N
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t               state;
  state_t               next_state;
  logic                 any_req;
  logic                 grant_sel;
  logic                 grant_b;
  logic                 we_r;
  logic [ADDR_W-1:0]    addr_r;
  logic [DATA_W-1:0]    wdata_r;
  logic [DATA_W/8-1:0]  be_r;
  logic [DATA_W-1:0]    rdata_r;
  logic                 dq_oe;

  assign any_req = a_req | b_req;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // last_b remembers which port won the previous grant; resetting it to B
  // makes A the first winner of a tie.
  logic last_b;

  always_comb begin
    if (a_req && b_req)
      grant_sel = ~last_b;
    else
      grant_sel = b_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_b <= 1'b1;
    else if (state == IDLE && any_req)
      last_b <= grant_sel;
  end
`else
  // Fixed priority: B only wins when A is not asking.
  assign grant_sel = ~a_req;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state logic: only IDLE looks at the requests
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = ACCESS;
      ACCESS:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request capture on entry to ACCESS, and read-data capture on the edge
  // that ends ACCESS (the SRAM has had a full cycle of OE_N low by then).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_b <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      be_r    <= '0;
      rdata_r <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        grant_b <= grant_sel;
        if (grant_sel) begin
          we_r    <= b_we;
          addr_r  <= b_addr;
          wdata_r <= b_wdata;
          be_r    <= b_be;
        end else begin
          we_r    <= a_we;
          addr_r  <= a_addr;
          wdata_r <= a_wdata;
          be_r    <= a_be;
        end
      end
      if (state == ACCESS && !we_r)
        rdata_r <= SRAM_DQ;
    end
  end

  // Output decode. WE_N pulses in ACCESS only, while write data stays on the
  // bus through DONE so the SRAM sees hold time after WE_N rises.
  always_comb begin
    SRAM_CE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    dq_oe     = 1'b0;
    a_ack     = 1'b0;
    b_ack     = 1'b0;
    case (state)
      ACCESS: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = we_r;
        SRAM_WE_N = ~we_r;
        SRAM_UB_N = ~be_r[1];
        SRAM_LB_N = ~be_r[0];
        dq_oe     = we_r;
      end
      DONE: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = we_r;
        SRAM_UB_N = ~be_r[1];
        SRAM_LB_N = ~be_r[0];
        dq_oe     = we_r;
        a_ack     = ~grant_b;
        b_ack     = grant_b;
      end
      default: ;
    endcase
  end

  assign SRAM_ADDR = addr_r;
  assign SRAM_DQ   = dq_oe ? wdata_r : {DATA_W{1'bz}};
  assign a_rdata   = rdata_r;
  assign b_rdata   = rdata_r;

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
//   Drives directed accesses into sram_arbiter against a small behavioural
//   SRAM. A transaction-level model tracks which request is in flight and
//   how far along it is; a compare process checks every SRAM pin and both
//   ack/rdata ports against it on each falling edge. Directed tests add
//   literal expectations for the reference scenarios. The data bus is a
//   tri1 net, so an undriven bus reads as all ones.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] BUS_FREE = 16'hFFFF;

  logic                clk = 1'b0;
  logic                reset;
  logic                a_req, a_we, b_req, b_we;
  logic [ADDR_W-1:0]   a_addr, b_addr;
  logic [DATA_W-1:0]   a_wdata, b_wdata;
  logic [1:0]          a_be, b_be;
  logic                a_ack, b_ack;
  logic [DATA_W-1:0]   a_rdata, b_rdata;
  logic [ADDR_W-1:0]   sram_addr;
  tri1  [DATA_W-1:0]   sram_dq;
  logic                ce_n, oe_n, we_n, ub_n, lb_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  // Behavioural SRAM: unwritten words read as addr ^ 0x5A5A.
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  int                mem_ver = 0;
  logic [DATA_W-1:0] mem_out;
  logic [DATA_W-1:0] mem_old;

  function automatic logic [DATA_W-1:0] mem_read(input logic [ADDR_W-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a[15:0] ^ 16'h5A5A;
  endfunction

  always @(sram_addr or mem_ver) mem_out = mem_read(sram_addr);

  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem_out : {DATA_W{1'bz}};

  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      mem_old = mem_read(sram_addr);
      mem[sram_addr] = {ub_n ? mem_old[15:8] : sram_dq[15:8],
                        lb_n ? mem_old[7:0]  : sram_dq[7:0]};
      mem_ver++;
    end
  end

  // Transaction model: ph = cycles since the grant (0 = nothing in flight).
  int                ph = 0;
  bit                m_gnt_b = 1'b0;
  bit                m_we = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic [1:0]        m_be = '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  bit                m_last_b = 1'b1;
`endif

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ph = 0;
      m_addr = '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      m_last_b = 1'b1;
`endif
    end else if (ph == 0) begin
      if (a_req || b_req) begin
        if (a_req && b_req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
          m_gnt_b = !m_last_b;
`else
          m_gnt_b = 1'b0;
`endif
        end else begin
          m_gnt_b = b_req;
        end
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        m_last_b = m_gnt_b;
`endif
        if (m_gnt_b) begin
          m_we = b_we; m_addr = b_addr; m_wdata = b_wdata; m_be = b_be;
        end else begin
          m_we = a_we; m_addr = a_addr; m_wdata = a_wdata; m_be = a_be;
        end
        ph = 1;
      end
    end else begin
      ph = (ph == 2) ? 0 : ph + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  bit                busy, rd;
  logic [DATA_W-1:0] exp_dq;

  always @(negedge clk) begin
    if (!reset) begin
      busy = (ph != 0);
      rd   = busy && !m_we;
      if (busy && m_we)  exp_dq = m_wdata;
      else if (rd)       exp_dq = mem_read(m_addr);
      else               exp_dq = BUS_FREE;
      checkOutput("ce_n", ce_n, !busy);
      checkOutput("oe_n", oe_n, !rd);
      checkOutput("we_n", we_n, !(ph == 1 && m_we));
      checkOutput("ub_n", ub_n, busy ? !m_be[1] : 1'b1);
      checkOutput("lb_n", lb_n, busy ? !m_be[0] : 1'b1);
      checkOutput("addr", sram_addr, m_addr);
      checkOutput("dq",   sram_dq, exp_dq);
      checkOutput("a_ack", a_ack, ph == 2 && !m_gnt_b);
      checkOutput("b_ack", b_ack, ph == 2 && m_gnt_b);
      if (ph == 2 && rd)
        checkOutput("rdata", m_gnt_b ? b_rdata : a_rdata, mem_read(m_addr));
    end
  end

  task automatic applyStimulus(input bit port_b, input bit req, input bit we,
                               input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata, input logic [1:0] be);
    if (port_b) begin
      b_req = req; b_we = we; b_addr = addr; b_wdata = wdata; b_be = be;
    end else begin
      a_req = req; a_we = we; a_addr = addr; a_wdata = wdata; a_be = be;
    end
  endtask

  // Counts falling edges until the port acks; -1 if the budget runs out.
  task automatic waitAck(input bit port_b, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if ((port_b ? b_ack : a_ack) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  int       n;
  int       acks;
  logic [3:0]  order;
  logic [15:0] ack_mask;

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, '0, '0, 2'b00);
    applyStimulus(1, 0, 0, '0, '0, 2'b00);
    mem[18'h12345] = 16'hBEEF;
    repeat (2) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_ce_n", ce_n, 1'b1);
    checkOutput("rst_we_n", we_n, 1'b1);
    checkOutput("rst_addr", sram_addr, 18'h0);
    checkOutput("rst_ack",  {a_ack, b_ack}, 2'b00);
    checkOutput("rst_dq",   sram_dq, BUS_FREE);
    checkOutput("rst_rdata", a_rdata, 16'h0000);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] A read 0x12345");
    applyStimulus(0, 1, 0, 18'h12345, 16'h0000, 2'b11);
    @(negedge clk);
    checkOutput("rd_access_ce_oe", {ce_n, oe_n}, 2'b00);
    @(negedge clk);
    checkOutput("rd_done_ce_oe", {ce_n, oe_n}, 2'b00);
    checkOutput("rd_a_ack", a_ack, 1'b1);
    checkOutput("rd_a_rdata", a_rdata, 16'hBEEF);
    checkOutput("rd_b_ack", b_ack, 1'b0);
    applyStimulus(0, 0, 0, '0, '0, 2'b00);
    @(negedge clk);
    checkOutput("rd_idle_ack", a_ack, 1'b0);

    $display("[TB] B write 0x00010 lower byte");
    applyStimulus(1, 1, 1, 18'h00010, 16'hA55A, 2'b01);
    @(negedge clk);
    checkOutput("wr_access_we_ub_lb", {we_n, ub_n, lb_n}, 3'b010);
    checkOutput("wr_access_dq", sram_dq, 16'hA55A);
    @(negedge clk);
    checkOutput("wr_done_we", we_n, 1'b1);
    checkOutput("wr_done_dq", sram_dq, 16'hA55A);
    checkOutput("wr_b_ack", b_ack, 1'b1);
    checkOutput("wr_a_ack", a_ack, 1'b0);
    applyStimulus(1, 0, 0, '0, '0, 2'b00);
    @(negedge clk);
    checkOutput("wr_idle_dq", sram_dq, BUS_FREE);

    $display("[TB] A read back 0x00010");
    applyStimulus(0, 1, 0, 18'h00010, 16'h0000, 2'b11);
    waitAck(0, 6, n);
    checkOutput("rb_latency", n, 2);
    checkOutput("rb_rdata", a_rdata, 16'h5A5A);
    applyStimulus(0, 0, 0, '0, '0, 2'b00);
    @(negedge clk);

    $display("[TB] B read with no byte enables");
    applyStimulus(1, 1, 0, 18'h00020, 16'h0000, 2'b00);
    @(negedge clk);
    checkOutput("be0_access", {ce_n, ub_n, lb_n}, 3'b011);
    @(negedge clk);
    checkOutput("be0_ack", b_ack, 1'b1);
    applyStimulus(1, 0, 0, '0, '0, 2'b00);
    @(negedge clk);

    $display("[TB] simultaneous requests, four accesses");
    applyStimulus(0, 1, 0, 18'h00100, 16'h0000, 2'b11);
    applyStimulus(1, 1, 0, 18'h00200, 16'h0000, 2'b11);
    order = '0;
    acks = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (a_ack || b_ack) begin
        order = {order[2:0], b_ack};
        acks++;
      end
    end
    applyStimulus(0, 0, 0, '0, '0, 2'b00);
    applyStimulus(1, 0, 0, '0, '0, 2'b00);
    checkOutput("tie_acks", acks, 4);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    checkOutput("tie_order", order, 4'b0101);
`else
    checkOutput("tie_order", order, 4'b0000);
`endif
    @(negedge clk);

    $display("[TB] reset during B write ACCESS");
    applyStimulus(1, 1, 1, 18'h00030, 16'h1234, 2'b11);
    @(negedge clk);
    checkOutput("abort_pre_we", we_n, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_we_n", we_n, 1'b1);
    checkOutput("abort_ce_n", ce_n, 1'b1);
    checkOutput("abort_dq", sram_dq, BUS_FREE);
    checkOutput("abort_b_ack", b_ack, 1'b0);
    @(negedge clk);
    checkOutput("abort_hold_ack", b_ack, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    waitAck(1, 6, n);
    checkOutput("reissue_latency", n, 2);
    applyStimulus(1, 0, 0, '0, '0, 2'b00);
    @(negedge clk);

    $display("[TB] back-to-back A reads");
    applyStimulus(0, 1, 0, 18'h00040, 16'h0000, 2'b11);
    ack_mask = '0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (a_ack) ack_mask[i] = 1'b1;
      if (i == 3 || i == 6) checkOutput("b2b_idle_oe", oe_n, 1'b1);
      if (i == 8) applyStimulus(0, 0, 0, '0, '0, 2'b00);
    end
    checkOutput("b2b_ack_cycles", ack_mask, 16'h0124);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 18, SRAM word-address width.
REQ-002 Parameter DATA_W, default 16, SRAM data width; byte enables are DATA_W/8 bits wide.
REQ-003 Ports, in order (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- a_req  in  1  requester A (video reader) access request, held until a_ack.
- a_we  in  1  A write=1 / read=0.
- a_addr  in  ADDR_W  A word address.
- a_wdata  in  DATA_W  A write data.
- a_be  in  2  A byte enables, bit1=upper byte, bit0=lower byte.
- a_ack  out  1  A access complete, one-cycle pulse.
- a_rdata  out  DATA_W  A read data, valid while a_ack=1.
- b_req, b_we, b_addr, b_wdata, b_be, b_ack, b_rdata  same as A, for requester B (CPU bridge).
- SRAM_ADDR  out  ADDR_W  SRAM address.
- SRAM_DQ  inout  DATA_W  SRAM data bus.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  SRAM controls, active-low.

Function
REQ-004 The FSM SHALL have states IDLE, ACCESS and DONE; IDLE->ACCESS on any sampled request, ACCESS->DONE unconditionally, DONE->IDLE unconditionally.
REQ-005 In IDLE with any req=1, the arbiter SHALL grant one port and register that port's we, addr, wdata and be on the same edge that enters ACCESS.
REQ-006 Fixed latency SHALL be: req sampled in IDLE at cycle t, ACCESS at t+1, ack at t+2 (DONE); 3 cycles per access; no pipelining.
REQ-007 In ACCESS and DONE: SRAM_CE_N=0, SRAM_ADDR=registered address, SRAM_UB_N/SRAM_LB_N=~registered be.
REQ-008 Read: SRAM_OE_N SHALL be 0 in ACCESS and DONE; SRAM_DQ is sampled on the edge ending ACCESS and presented on the granted port's rdata during DONE.
REQ-009 Write: SRAM_WE_N SHALL be 0 in ACCESS only; SRAM_DQ is driven with the registered wdata in ACCESS and DONE (data hold); SRAM_OE_N=1.
REQ-010 SRAM_DQ SHALL be high-Z in every state except a write's ACCESS and DONE.
REQ-011 In IDLE: CE_N, OE_N, WE_N, UB_N, LB_N SHALL all be 1; SRAM_ADDR holds its last value.
REQ-012 Only the granted port's ack SHALL pulse, for exactly one cycle in DONE; rdata is don't-care outside DONE, and for writes.
REQ-013 Requests sampled outside IDLE SHALL be ignored; a req held high after its ack is treated as a new request in the next IDLE.
REQ-014 A request with be=2'b00 SHALL still complete the full cycle and ack, with UB_N=LB_N=1 (no byte written/read).
REQ-015 Address SHALL be passed unmodified; no wrap or range checking.

Reset
REQ-016 Reset asserted SHALL immediately force IDLE, a_ack=b_ack=0, all SRAM controls to 1, SRAM_DQ to high-Z, SRAM_ADDR=0, rdata registers=0, last-grant=B.
REQ-017 Reset during ACCESS or DONE SHALL abort the access with no ack; the requester reissues after reset release.

Configuration
REQ-018 Macro SRAM_ARB_ROUND_ROBIN_EN defined: on simultaneous a_req and b_req in IDLE, the grant SHALL go to the port not granted last (last-grant register updated on each grant; reset value B, so A wins first).
REQ-019 Macro undefined: A SHALL always win simultaneous requests (fixed priority); no last-grant register is built.
REQ-020 Single-requester behaviour SHALL be identical in both builds.

Verification
REQ-021 A read, addr=0x12345, SRAM model returns 0xBEEF -> CE_N/OE_N low in cycles t+1..t+2, a_ack=1 with a_rdata=0xBEEF at t+2, b_ack stays 0.
REQ-022 B write, addr=0x00010, wdata=0xA55A, be=2'b01 -> WE_N low for one cycle, LB_N=0, UB_N=1, DQ=0xA55A in ACCESS and DONE, then Z; b_ack at t+2.
REQ-023 a_req and b_req held high together for 4 accesses -> with macro, grant order A,B,A,B; without macro, A,A,A,A and b_ack never pulses.
REQ-024 Reset asserted in the ACCESS cycle of a B write -> WE_N returns to 1 and DQ goes to Z without a clock edge; no b_ack; after release, B reissues and completes in 3 cycles.
REQ-025 Back-to-back A reads, req held high -> acks at cycles 2, 5, 8; DQ never driven; OE_N=1 in each IDLE cycle.
